// File: rtl/display_scan_controller.sv
// -----------------------------------------------------------------------------
// display_scan_controller
//   Source side of a 4-digit multiplexed 7-segment display. Time-multiplexes the
//   clock (hh:mm) or a scrolling date ring onto a shared digit/address bus for
//   the downstream digit decoder, and drives the active-low digit enables.
//   The decoder registers segments one cycle late, so anodes_out is produced
//   from the previous cycle's address to line up with the segments.
//
// Ports
//   clk_in         in   1  single clock, rising edge
//   nreset_in      in   1  asynchronous active-low reset
//   mode_in        in   2  01 clock hh:mm, 10 scrolling date, 00/11 display off
//   sync_valid_in  in   1  time fields valid (DCF77 locked)
//   sec_pulse_in   in   1  one-cycle pulse per second
//   hour_in        in   8  BCD hour
//   minute_in      in   8  BCD minute
//   day_in         in   8  BCD day
//   month_in       in   8  BCD month
//   year_in        in   8  BCD year (yy)
//   digit_out      out  4  nibble for current slot (0-9, 10 blank, 11 dash)
//   address_out    out  2  current slot, 3 = leftmost
//   type_out       out  2  registered display mode (00 when off)
//   loopindex_out  out  6  scroll ring start position
//   flag_sec_out   out  1  toggles on each accepted second pulse
//   anodes_out     out  4  active-low digit enable, bit n = address n
// -----------------------------------------------------------------------------
module display_scan_controller #(
    parameter int SCAN_DIV   = 4096,
    parameter int SCROLL_DIV = 64,
    parameter int LOOP_LEN   = 12
) (
    input  logic       clk_in,
    input  logic       nreset_in,
    input  logic [1:0] mode_in,
    input  logic       sync_valid_in,
    input  logic       sec_pulse_in,
    input  logic [7:0] hour_in,
    input  logic [7:0] minute_in,
    input  logic [7:0] day_in,
    input  logic [7:0] month_in,
    input  logic [7:0] year_in,
    output logic [3:0] digit_out,
    output logic [1:0] address_out,
    output logic [1:0] type_out,
    output logic [5:0] loopindex_out,
    output logic       flag_sec_out,
    output logic [3:0] anodes_out
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int FW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FRM_LAST  = FW'(SCROLL_DIV - 1);
    localparam logic [5:0]    LOOP_LAST = 6'(LOOP_LEN - 1);

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_CLOCK = 2'b01;
    localparam logic [1:0] MODE_DATE  = 2'b10;
    localparam logic [3:0] NIB_BLANK  = 4'hA;
    localparam logic [3:0] NIB_DASH   = 4'hB;

    // Ring position shown at slot addr; sum stays below 2*LOOP_LEN so one subtract wraps it.
    function automatic logic [6:0] ring_pos(input logic [5:0] li, input logic [1:0] addr);
        logic [6:0] sum;
        sum = {1'b0, li} + 7'd3 - {5'b00000, addr};
        if (sum >= 7'(LOOP_LEN)) begin
            return sum - 7'(LOOP_LEN);
        end else begin
            return sum;
        end
    endfunction

    // Date ring: d1 d0 - m1 m0 - y1 y0, then blanks up to LOOP_LEN.
    function automatic logic [3:0] ring_nibble(input logic [6:0] pos, input logic [7:0] d,
                                               input logic [7:0] m, input logic [7:0] y);
        case (pos)
            7'd0:    return d[7:4];
            7'd1:    return d[3:0];
            7'd2:    return NIB_DASH;
            7'd3:    return m[7:4];
            7'd4:    return m[3:0];
            7'd5:    return NIB_DASH;
            7'd6:    return y[7:4];
            7'd7:    return y[3:0];
            default: return NIB_BLANK;
        endcase
    endfunction

    // Clock layout: addr3..0 = h1 h0 m1 m0.
    function automatic logic [3:0] clock_nibble(input logic [1:0] addr, input logic [7:0] h,
                                                input logic [7:0] m);
        case (addr)
            2'd3:    return h[7:4];
            2'd2:    return h[3:0];
            2'd1:    return m[7:4];
            default: return m[3:0];
        endcase
    endfunction

    logic [PW-1:0] prescaler_r, prescaler_s;
    logic [FW-1:0] frame_r, frame_s;
    logic [1:0]    address_r, address_s;
    logic [1:0]    type_r, type_s;
    logic [5:0]    loopindex_r, loopindex_s;
    logic [3:0]    digit_r, digit_s;
    logic [3:0]    anodes_r, anodes_s;
    logic          flag_r, flag_s;
    logic [7:0]    hour_r, hour_s, minute_r, minute_s;
    logic [7:0]    day_r, day_s, month_r, month_s, year_r, year_s;
    logic [1:0]    mode_eff_s;
    logic          slot_end_s, frame_end_s;

    // Next-state logic for scan timing, scroll position, data snapshots and outputs.
    always_comb begin
        prescaler_s = prescaler_r;
        frame_s     = frame_r;
        address_s   = address_r;
        type_s      = type_r;
        loopindex_s = loopindex_r;
        hour_s      = hour_r;
        minute_s    = minute_r;
        day_s       = day_r;
        month_s     = month_r;
        year_s      = year_r;

        case (mode_in)
            MODE_CLOCK: mode_eff_s = MODE_CLOCK;
            MODE_DATE:  mode_eff_s = MODE_DATE;
            default:    mode_eff_s = MODE_OFF;
        endcase

        slot_end_s  = (prescaler_r == PRE_LAST);
        frame_end_s = slot_end_s && (address_r == 2'd0);

        if (mode_eff_s != type_r) begin
            // Mode change wins over any coincident terminal count.
            type_s      = mode_eff_s;
            address_s   = 2'd3;
            loopindex_s = 6'd0;
            prescaler_s = '0;
            frame_s     = '0;
            hour_s      = hour_in;
            minute_s    = minute_in;
            day_s       = day_in;
            month_s     = month_in;
            year_s      = year_in;
        end else if (type_r == MODE_OFF) begin
            address_s   = 2'd3;
            loopindex_s = 6'd0;
            prescaler_s = '0;
            frame_s     = '0;
        end else begin
            if (slot_end_s) begin
                prescaler_s = '0;
                address_s   = address_r - 2'd1;
            end else begin
                prescaler_s = prescaler_r + PW'(1);
            end
            if (frame_end_s) begin
                // Snapshot at frame end so one frame never mixes two minutes.
                hour_s   = hour_in;
                minute_s = minute_in;
                if (frame_r == FRM_LAST) begin
                    frame_s = '0;
                    if (type_r == MODE_DATE) begin
                        if (loopindex_r == LOOP_LAST) begin
                            loopindex_s = 6'd0;
                            day_s       = day_in;
                            month_s     = month_in;
                            year_s      = year_in;
                        end else begin
                            loopindex_s = loopindex_r + 6'd1;
                        end
                    end else begin
                        loopindex_s = loopindex_r;
                    end
                end else begin
                    frame_s = frame_r + FW'(1);
                end
            end else begin
                frame_s = frame_r;
            end
        end

        // Digit follows the slot being entered so address and digit change together.
        if (type_s == MODE_OFF) begin
            digit_s = NIB_BLANK;
        end else if (!sync_valid_in) begin
            digit_s = NIB_DASH;
        end else if (type_s == MODE_CLOCK) begin
            digit_s = clock_nibble(address_s, hour_s, minute_s);
        end else begin
            digit_s = ring_nibble(ring_pos(loopindex_s, address_s), day_s, month_s, year_s);
        end

        // Built from the current address, giving the one-cycle lag the decoder expects.
        if (type_r == MODE_OFF) begin
            anodes_s = 4'b1111;
        end else begin
            anodes_s = ~(4'b0001 << address_r);
        end

        if (!sync_valid_in) begin
            flag_s = 1'b0;
        end else if (sec_pulse_in) begin
            flag_s = ~flag_r;
        end else begin
            flag_s = flag_r;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk_in or negedge nreset_in) begin
        if (!nreset_in) begin
            prescaler_r <= '0;
            frame_r     <= '0;
            address_r   <= 2'd3;
            type_r      <= MODE_OFF;
            loopindex_r <= 6'd0;
            digit_r     <= NIB_BLANK;
            anodes_r    <= 4'b1111;
            flag_r      <= 1'b0;
            hour_r      <= 8'h00;
            minute_r    <= 8'h00;
            day_r       <= 8'h00;
            month_r     <= 8'h00;
            year_r      <= 8'h00;
        end else begin
            prescaler_r <= prescaler_s;
            frame_r     <= frame_s;
            address_r   <= address_s;
            type_r      <= type_s;
            loopindex_r <= loopindex_s;
            digit_r     <= digit_s;
            anodes_r    <= anodes_s;
            flag_r      <= flag_s;
            hour_r      <= hour_s;
            minute_r    <= minute_s;
            day_r       <= day_s;
            month_r     <= month_s;
            year_r      <= year_s;
        end
    end

    assign digit_out     = digit_r;
    assign address_out   = address_r;
    assign type_out      = type_r;
    assign loopindex_out = loopindex_r;
    assign flag_sec_out  = flag_r;
    assign anodes_out    = anodes_r;

endmodule
